// File: rtl/pwm_capture.sv
// Per-channel PWM high-time capture over one hsync-opened window, results drained one channel per accept.
// Capture lasts WINDOW cycles; the drain holds each result stable until accepted; hsync edges outside IDLE only set overrun.
module pwm_capture #(
  parameter int STAGE  = 8,
  parameter int DWIDTH = 8,
  parameter int WINDOW = 255,
  localparam int IW = (STAGE > 1) ? $clog2(STAGE) : 1
) (
  input  logic              clkforcounter,
  input  logic              rst,
  input  logic              hsync,
  input  logic [0:STAGE-1]  pwm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [IW-1:0]     out_idx,
  output logic              out_err,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [DWIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WW-1:0]     WIN_LAST = WW'(WINDOW - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(STAGE - 1);

  logic [1:0]        state_q, state_d;
  logic              hs_q;
  logic [WW-1:0]     win_q, win_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic [DWIDTH-1:0] cnt_q [STAGE];
  logic [DWIDTH-1:0] cnt_d [STAGE];
  logic [STAGE-1:0]  err_q, err_d;
  logic [STAGE-1:0]  seen_q, seen_d;
  logic [STAGE-1:0]  prev_q, prev_d;
  logic              hs_edge;

  assign hs_edge = hsync & ~hs_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    seen_d  = seen_q;
    prev_d  = prev_q;
    case (state_q)
      S_IDLE: begin
        if (hs_edge) begin
          state_d = S_CAPTURE;
          win_d   = '0;
          ovr_d   = 1'b0;
          err_d   = '0;
          seen_d  = '0;
          prev_d  = '0;
          for (int i = 0; i < STAGE; i++) cnt_d[i] = '0;
        end
      end
      S_CAPTURE: begin
        if (hs_edge) ovr_d = 1'b1;
        // A rise on a channel that has already been high in this window is a second pulse.
        for (int i = 0; i < STAGE; i++) begin
          if (pwm_in[i]) begin
            if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
            if (!prev_q[i] && seen_q[i]) err_d[i] = 1'b1;
            seen_d[i] = 1'b1;
          end
          prev_d[i] = pwm_in[i];
        end
        win_d = win_q + 1'b1;
        if (win_q == WIN_LAST) begin
          state_d = S_DRAIN;
          vld_d   = 1'b1;
          idx_d   = '0;
        end
      end
      S_DRAIN: begin
        if (hs_edge) ovr_d = 1'b1;
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkforcounter) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hs_q    <= 1'b0;
      win_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= '0;
      seen_q  <= '0;
      prev_q  <= '0;
      for (int i = 0; i < STAGE; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      hs_q    <= hsync;
      win_q   <= win_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      prev_q  <= prev_d;
      for (int i = 0; i < STAGE; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid = vld_q;
  assign out_idx   = idx_q;
  assign out_data  = vld_q ? cnt_q[idx_q] : '0;
  assign out_err   = vld_q ? err_q[idx_q] : 1'b0;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign overrun   = ovr_q;

endmodule
